unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
//  - Shares one single-port unified memory between the core's instruction-fetch port (F) and its load/store port (D).
//  - Sits between the program counter/fetch path and the data-memory path on one side and the memory macro on the other.
//  - Serialises accesses with a grant/response handshake.
//  - Data has fixed priority, bounded by an anti-starvation counter that guarantees fetch progress.
// PARAMETERS
//  - MEM_LAT     2   memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..8.
//  - STARVE_MAX  3   consecutive D grants allowed while F is pending before F is forced to win; legal range 1..15.
// PORTS
//  clk          in   1   system clock; all state updates on rising edge
//  rstn         in   1   synchronous active-low reset
//  f_req        in   1   fetch request; held with f_addr stable until f_gnt
//  f_addr       in   32  fetch byte address
//  f_gnt        out  1   fetch request accepted (1-cycle pulse)
//  f_rvalid     out  1   fetch response valid (1-cycle pulse)
//  f_rdata      out  32  fetch read data, valid with f_rvalid
//  d_req        in   1   data request; held with d_addr/d_we/d_wdata stable until d_gnt
//  d_addr       in   32  data byte address
//  d_we         in   4   byte write enables; 4'b0000 = read
//  d_wdata      in   32  store data
//  d_gnt        out  1   data request accepted (1-cycle pulse)
//  d_rvalid     out  1   data response/write ack (1-cycle pulse)
//  d_rdata      out  32  data read data, valid with d_rvalid
//  mem_en       out  1   memory access strobe
//  mem_we       out  4   memory byte write enables
//  mem_addr     out  32  memory byte address
//  mem_wdata    out  32  memory write data
//  mem_rdata    in   32  memory read data, valid MEM_LAT cycles after mem_en
//  busy         out  1   high while an access is outstanding (state BUSY)
//  perf_f_grants out 32  fetch grant count
//  perf_d_grants out 32  data grant count
//  perf_f_stall  out 32  cycles with f_req=1 and f_gnt=0
// BEHAVIOUR
//  - Reset (rstn=0 at a clk edge):
//    - State returns to IDLE; latency counter, starve_cnt and perf counters are cleared.
//    - While rstn=0, all outputs are forced to 0 regardless of f_req/d_req.
//  - States:
//    - IDLE: arbitrate each cycle. On grant, go to BUSY with lat_cnt = MEM_LAT-1 and latch owner (F or D).
//    - BUSY: lat_cnt decrements each cycle. In the cycle lat_cnt==0, assert owner's rvalid and return to IDLE.
//  - Arbitration in IDLE (combinational, same cycle):
//    - D wins if d_req=1, unless f_req=1 and starve_cnt==STARVE_MAX, in which case F wins.
//    - F wins if f_req=1 and d_req=0.
//    - Exactly one gnt is asserted per grant; no gnt is asserted in BUSY.
//  - Memory drive in the grant cycle:
//    - mem_en=1, mem_addr = winner addr.
//    - mem_we = d_we for D; 4'b0000 for F.
//    - mem_wdata = d_wdata for D; 0 for F.
//    - Outside the grant cycle, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
//  - Response: owner rdata = mem_rdata in the rvalid cycle. Stores also pulse d_rvalid, with d_rdata = mem_rdata (don't-care).
//  - Throughput: at most one access per MEM_LAT+1 cycles. The earliest next grant is the cycle after rvalid.
//  - starve_cnt (4 bit):
//    - Increments on a D grant while f_req=1.
//    - Clears on any F grant, and on a D grant with f_req=0.
//    - Never exceeds STARVE_MAX.
//  - Reset mid-BUSY: the outstanding access is abandoned, no rvalid is issued, and arbitration restarts in IDLE after rstn rises.
//  - A req deasserted before gnt is a protocol violation; the arbiter arbitrates on current inputs only.
//  - busy = (state==BUSY).
// CONFIGURATION
//  - MEM_ARB_PERF_EN defined:
//    - perf_* are 32-bit counters, wrapping modulo 2^32.
//    - perf_f_grants/perf_d_grants increment on f_gnt/d_gnt.
//    - perf_f_stall increments each cycle with f_req & ~f_gnt, including BUSY cycles.
//  - MEM_ARB_PERF_EN undefined: perf_* ports remain present and are tied to 32'h0; no counter flops.
// TESTING
//  1. Reset: rstn=0, f_req=d_req=1 for 3 cycles -> all outputs 0, busy=0, no gnt.
//  2. Single fetch, MEM_LAT=2: f_req=1, f_addr=0x10 at cycle 0
//     -> cycle 0: f_gnt=1, mem_en=1, mem_addr=0x10, mem_we=0
//     -> cycle 2: f_rvalid=1 with f_rdata = mem_rdata (e.g. 0x00500093).
//  3. Simultaneous requests: f_req=d_req=1, d_addr=0x2000, d_we=4'hF, d_wdata=0xDEADBEEF
//     -> d_gnt at cycle 0 with mem_we=4'hF, mem_wdata=0xDEADBEEF
//     -> d_rvalid at cycle 2
//     -> f_gnt at cycle 3.
//  4. Starvation, STARVE_MAX=2, f_req and d_req held continuously -> grant order D,D,F,D,D,F, with one grant per 3 cycles.
//  5. Reset mid-BUSY: rstn=0 in the cycle after d_gnt -> no d_rvalid; after rstn=1 with d_req=1, d_gnt is issued next cycle.
//  6. Perf: 3 fetches + 2 reads -> with MEM_ARB_PERF_EN, perf_f_grants=3 and perf_d_grants=2; without it, both read 0.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between instruction fetch (F) and load/store (D).
// Optional performance counters are built when MEM_ARB_PERF_EN is defined; otherwise perf_* read 0.
module unified_mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [31:0] perf_f_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_f_stall
);

    // Handshake: a requester holds req and its address/data stable until the
    // one-cycle gnt; each gnt is answered by exactly one rvalid pulse MEM_LAT cycles later.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic        own_data_q, own_data_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] addr_q, wdata_q;
    logic        grant_f, grant_d, rsp;

    always_comb begin : arbitrate
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (f_req && (!d_req || starve_q == STARVE_LIM)) begin
                grant_f = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    assign rsp = (state_q == BUSY) && (lat_q == 4'd0);

    always_comb begin : next_state
        state_d    = state_q;
        lat_d      = lat_q;
        own_data_d = own_data_q;
        starve_d   = starve_q;
        case (state_q)
            IDLE: begin
                if (grant_f || grant_d) begin
                    state_d    = BUSY;
                    lat_d      = LAT_INIT;
                    own_data_d = grant_d;
                end
            end
            BUSY: begin
                if (lat_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Saturating count of D wins taken while F was waiting.
        if (grant_f) begin
            starve_d = 4'd0;
        end else if (grant_d) begin
            if (!f_req) begin
                starve_d = 4'd0;
            end else if (starve_q < STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            lat_q      <= 4'd0;
            own_data_q <= 1'b0;
            starve_q   <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            own_data_q <= own_data_d;
            starve_q   <= starve_d;
            if (grant_f) begin
                addr_q  <= f_addr;
                wdata_q <= 32'h0;
            end else if (grant_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
            end
        end
    end

    // Every output is held at zero while reset is asserted.
    always_comb begin : drive
        f_gnt     = 1'b0;
        d_gnt     = 1'b0;
        f_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        f_rdata   = 32'h0;
        d_rdata   = 32'h0;
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        busy      = 1'b0;
        if (rstn) begin
            f_gnt     = grant_f;
            d_gnt     = grant_d;
            mem_en    = grant_f | grant_d;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (grant_f) begin
                mem_addr  = f_addr;
                mem_wdata = 32'h0;
            end else if (grant_d) begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_we    = d_we;
            end
            f_rvalid = rsp & ~own_data_q;
            d_rvalid = rsp & own_data_q;
            if (rsp && !own_data_q) f_rdata = mem_rdata;
            if (rsp && own_data_q)  d_rdata = mem_rdata;
            busy = (state_q == BUSY);
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] f_grants_q, d_grants_q, f_stall_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            f_grants_q <= 32'h0;
            d_grants_q <= 32'h0;
            f_stall_q  <= 32'h0;
        end else begin
            if (grant_f) f_grants_q <= f_grants_q + 32'd1;
            if (grant_d) d_grants_q <= d_grants_q + 32'd1;
            if (f_req && !grant_f) f_stall_q <= f_stall_q + 32'd1;
        end
    end

    assign perf_f_grants = rstn ? f_grants_q : 32'h0;
    assign perf_d_grants = rstn ? d_grants_q : 32'h0;
    assign perf_f_stall  = rstn ? f_stall_q  : 32'h0;
`else
    assign perf_f_grants = 32'h0;
    assign perf_d_grants = 32'h0;
    assign perf_f_stall  = 32'h0;
`endif

endmodule
